// File: rtl/first_gate_pkg.sv
// Shared definitions for the registered two-input gate unit: op codes and sizes.
package first_gate_pkg;

    localparam int OP_W    = 3;
    localparam int NUM_OPS = 8;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_BUF_A = 3'd7
    } op_e;

    // Base bit of an op's slice inside the packed all-functions vector.
    function automatic int op_base(input int op, input int width);
        return op * width;
    endfunction

endpackage

// File: rtl/first_gate_gate_eval.sv
// Combinational evaluation of all eight two-input functions, bitwise per lane.
// Slice k of all_o (k*WIDTH +: WIDTH) holds the result of op code k.
module gate_eval
    import first_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic [NUM_OPS*WIDTH-1:0] all_o
);

    // Each lane is independent; ops NOT a and BUF a deliberately ignore b.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        assign all_o[op_base(int'(OP_AND),   WIDTH) + gi] =   a[gi] & b[gi];
        assign all_o[op_base(int'(OP_OR),    WIDTH) + gi] =   a[gi] | b[gi];
        assign all_o[op_base(int'(OP_NAND),  WIDTH) + gi] = ~(a[gi] & b[gi]);
        assign all_o[op_base(int'(OP_NOR),   WIDTH) + gi] = ~(a[gi] | b[gi]);
        assign all_o[op_base(int'(OP_XOR),   WIDTH) + gi] =   a[gi] ^ b[gi];
        assign all_o[op_base(int'(OP_XNOR),  WIDTH) + gi] = ~(a[gi] ^ b[gi]);
        assign all_o[op_base(int'(OP_NOT_A), WIDTH) + gi] =  ~a[gi];
        assign all_o[op_base(int'(OP_BUF_A), WIDTH) + gi] =   a[gi];
    end

endmodule

// File: rtl/first_gate.sv
// Registered two-input gate unit: held op register, registered selected result,
// registered all-function bus and a one-cycle-delayed valid flag.
module first_gate
    import first_gate_pkg::*;
#(
    parameter int              WIDTH      = 1,
    parameter logic [OP_W-1:0] DEFAULT_OP = 3'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     in_valid,
    input  logic                     op_we,
    input  logic [OP_W-1:0]          op_sel,
    output logic [WIDTH-1:0]         c,
    output logic [NUM_OPS*WIDTH-1:0] all_q,
    output logic                     out_valid,
    output logic [OP_W-1:0]          op_q
);

    logic [NUM_OPS*WIDTH-1:0] eval_all;
    logic [NUM_OPS*WIDTH-1:0] all_d;
    logic [WIDTH-1:0]         c_q;
    logic [WIDTH-1:0]         c_d;
    logic [OP_W-1:0]          op_d;
    logic [OP_W-1:0]          op_eff;
    logic                     out_valid_q;
    logic                     out_valid_d;

    gate_eval #(
        .WIDTH (WIDTH)
    ) u_gate_eval (
        .a     (a),
        .b     (b),
        .all_o (eval_all)
    );

    // Next-state: a same-edge op write applies to the sample taken on that edge;
    // results only update on valid samples, so an op change never re-evaluates a held result.
    always_comb begin
        op_d        = op_q;
        c_d         = c_q;
        all_d       = all_q;
        out_valid_d = in_valid;
        op_eff      = op_we ? op_sel : op_q;
        if (op_we) begin
            op_d = op_sel;
        end
        if (in_valid) begin
            all_d = eval_all;
            c_d   = eval_all[op_base(int'(op_eff), WIDTH) +: WIDTH];
        end
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= DEFAULT_OP;
            c_q         <= '0;
            all_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            c_q         <= c_d;
            all_q       <= all_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_first_gate.sv
// Self-checking bench for first_gate: a WIDTH=1 and a WIDTH=4 instance share clock,
// reset and control; expected results are queued at drive time and popped after the edge.
module tb_first_gate;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       op_we;
    logic [2:0] op_sel;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;

    logic [0:0]  c1;
    logic [7:0]  all1;
    logic        ov1;
    logic [2:0]  opq1;
    logic [3:0]  c4;
    logic [31:0] all4;
    logic        ov4;
    logic [2:0]  opq4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [0:0]  c1;
        logic [7:0]  all1;
        logic [3:0]  c4;
        logic [31:0] all4;
        logic        valid;
        logic [2:0]  op;
    } exp_t;

    exp_t sb_q[$];

    // Reference state of the bench model.
    logic [0:0]  m_c1;
    logic [7:0]  m_all1;
    logic [3:0]  m_c4;
    logic [31:0] m_all4;
    logic [2:0]  m_op;

    first_gate #(.WIDTH(1), .DEFAULT_OP(3'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
        .op_we(op_we), .op_sel(op_sel), .c(c1), .all_q(all1),
        .out_valid(ov1), .op_q(opq1)
    );

    first_gate #(.WIDTH(4), .DEFAULT_OP(3'd0)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid),
        .op_we(op_we), .op_sel(op_sel), .c(c4), .all_q(all4),
        .out_valid(ov4), .op_q(opq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth tables indexed by {a,b}: bit i is the output for {a,b}==i.
    function automatic logic tt(input int op, input logic x, input logic y);
        logic [3:0] t;
        case (op)
            0: t = 4'b1000;
            1: t = 4'b1110;
            2: t = 4'b0111;
            3: t = 4'b0001;
            4: t = 4'b0110;
            5: t = 4'b1001;
            6: t = 4'b0011;
            default: t = 4'b1100;
        endcase
        return t[{x, y}];
    endfunction

    function automatic logic [7:0] model1(input logic x, input logic y);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = tt(k, x, y);
        return r;
    endfunction

    function automatic logic [31:0] model4(input logic [3:0] x, input logic [3:0] y);
        logic [31:0] r;
        for (int k = 0; k < 8; k++)
            for (int l = 0; l < 4; l++)
                r[k*4 + l] = tt(k, x[l], y[l]);
        return r;
    endfunction

    task automatic model_reset();
        m_c1 = '0; m_all1 = '0; m_c4 = '0; m_all4 = '0; m_op = 3'd0;
        sb_q.delete();
    endtask

    // One clock: drive at the current (falling) edge, push expectation, compare after rising edge.
    task automatic cycle(input string name, input logic [0:0] xa1, input logic [0:0] xb1,
                         input logic [3:0] xa4, input logic [3:0] xb4,
                         input logic v, input logic we, input logic [2:0] sel);
        exp_t e;
        logic [2:0] eff;
        a1 = xa1; b1 = xb1; a4 = xa4; b4 = xb4;
        in_valid = v; op_we = we; op_sel = sel;
        eff = we ? sel : m_op;
        if (v) begin
            m_all1 = model1(xa1[0], xb1[0]);
            m_all4 = model4(xa4, xb4);
            m_c1   = m_all1[eff];
            m_c4   = {m_all4[eff*4+3], m_all4[eff*4+2], m_all4[eff*4+1], m_all4[eff*4]};
        end
        if (we) m_op = sel;
        e.c1 = m_c1; e.all1 = m_all1; e.c4 = m_c4; e.all4 = m_all4; e.valid = v; e.op = m_op;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (c1 !== e.c1 || all1 !== e.all1 || ov1 !== e.valid || opq1 !== e.op) begin
            failures++;
            $display("FAIL %s w1: got c=%h all=%h v=%b op=%0d expected c=%h all=%h v=%b op=%0d",
                     name, c1, all1, ov1, opq1, e.c1, e.all1, e.valid, e.op);
        end
        checks++;
        if (c4 !== e.c4 || all4 !== e.all4 || ov4 !== e.valid || opq4 !== e.op) begin
            failures++;
            $display("FAIL %s w4: got c=%h all=%h v=%b op=%0d expected c=%h all=%h v=%b op=%0d",
                     name, c4, all4, ov4, opq4, e.c4, e.all4, e.valid, e.op);
        end
        $display("txn %-12s a1=%b b1=%b a4=%h b4=%h v=%b we=%b sel=%0d -> c1=%b c4=%h all1=%h ov=%b op=%0d",
                 name, xa1, xb1, xa4, xb4, v, we, sel, c1, c4, all1, ov1, opq1);
        @(negedge clk);
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (c1 !== 1'b0 || all1 !== 8'h00 || ov1 !== 1'b0 || opq1 !== 3'd0 ||
            c4 !== 4'h0 || all4 !== 32'h0 || ov4 !== 1'b0 || opq4 !== 3'd0) begin
            failures++;
            $display("FAIL %s: got c1=%b all1=%h v1=%b op1=%0d c4=%h all4=%h v4=%b op4=%0d expected all zero",
                     name, c1, all1, ov1, opq1, c4, all4, ov4, opq4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; op_we = 1'b1; op_sel = 3'd5;
        a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'h3;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        in_valid = 1'b0; op_we = 1'b0;
    endtask

    task automatic test_and_sweep();
        logic [7:0] want [4];
        logic [1:0] ab;
        want[0] = 8'h6C; want[1] = 8'h96; want[2] = 8'h56; want[3] = 8'hA3;
        for (int i = 0; i < 4; i++) begin
            ab = (i == 0) ? 2'b00 : (i == 1) ? 2'b10 : (i == 2) ? 2'b01 : 2'b11;
            cycle("and_sweep", ab[1], ab[0], 4'(i * 3), 4'(15 - i), 1'b1, 1'b0, 3'd0);
            checks++;
            if (all1 !== want[i] || c1 !== ((i == 3) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL and_sweep_const: got all=%h c=%b expected all=%h c=%b",
                         all1, c1, want[i], (i == 3));
            end
        end
    endtask

    task automatic test_write_through();
        cycle("xor_wt", 1'b1, 1'b1, 4'h5, 4'h6, 1'b1, 1'b1, 3'd4);
        checks++;
        if (c1 !== 1'b0) begin
            failures++;
            $display("FAIL xor_wt_c: got %b expected 0", c1);
        end
        cycle("xor_next", 1'b1, 1'b0, 4'h9, 4'h3, 1'b1, 1'b0, 3'd0);
        checks++;
        if (c1 !== 1'b1 || opq1 !== 3'd4) begin
            failures++;
            $display("FAIL xor_next: got c=%b op=%0d expected c=1 op=4", c1, opq1);
        end
    endtask

    task automatic test_wide();
        cycle("nand_w4", 1'b0, 1'b1, 4'b1100, 4'b1010, 1'b1, 1'b1, 3'd2);
        checks++;
        if (c4 !== 4'b0111) begin
            failures++;
            $display("FAIL nand_w4: got %b expected 0111", c4);
        end
        cycle("nota_w4", 1'b0, 1'b1, 4'b1100, 4'b1010, 1'b1, 1'b1, 3'd6);
        checks++;
        if (c4 !== 4'b0011) begin
            failures++;
            $display("FAIL nota_w4: got %b expected 0011", c4);
        end
    endtask

    task automatic test_hold();
        logic [3:0]  sc4;
        logic [31:0] sa4;
        sc4 = c4; sa4 = all4;
        cycle("idle0", 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 3'd0);
        cycle("idle_opwr", 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 3'd1);
        cycle("idle2", 1'b1, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 3'd0);
        checks++;
        if (c4 !== sc4 || all4 !== sa4 || ov4 !== 1'b0 || opq4 !== 3'd1) begin
            failures++;
            $display("FAIL hold: got c=%h all=%h v=%b op=%0d expected c=%h all=%h v=0 op=1",
                     c4, all4, ov4, opq4, sc4, sa4);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r;
        for (int i = 0; i < 24; i++) begin
            r = 4'($urandom_range(0, 15));
            cycle("b2b", r[0], r[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_midstream_reset();
        cycle("pre_rst", 1'b1, 1'b1, 4'hC, 4'h6, 1'b1, 1'b1, 3'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("rst_immediate");
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        cycle("post_idle", 1'b1, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0, 3'd0);
        cycle("post_first", 1'b1, 1'b0, 4'h6, 4'h3, 1'b1, 1'b0, 3'd0);
        checks++;
        if (ov1 !== 1'b1 || c1 !== 1'b0 || c4 !== 4'h2) begin
            failures++;
            $display("FAIL post_first: got v=%b c1=%b c4=%h expected v=1 c1=0 c4=2", ov1, c1, c4);
        end
    endtask

    initial begin
        in_valid = 1'b0; op_we = 1'b0; op_sel = 3'd0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; rst_n = 1'b0;
        model_reset();
        test_reset();
        test_and_sweep();
        test_write_through();
        test_wide();
        test_hold();
        test_back_to_back();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
